// File: rtl/qspi_wr_pkg.sv
// ============================================================================
// Module : qspi_wr_pkg
// Brief  : Opcodes, register offsets, operation codes and FSM states shared
//          by the SPI flash programmer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package qspi_wr_pkg;

    localparam logic [7:0] c_OP_WREN = 8'h06;
    localparam logic [7:0] c_OP_PP   = 8'h02;
    localparam logic [7:0] c_OP_QPP  = 8'h32;
    localparam logic [7:0] c_OP_SE   = 8'h20;
    localparam logic [7:0] c_OP_RDSR = 8'h05;

    // HADDR[4:2] register decode; DATA0-3 occupy codes 4-7
    localparam logic [2:0] c_REG_ADDR   = 3'd0;
    localparam logic [2:0] c_REG_CTRL   = 3'd1;
    localparam logic [2:0] c_REG_STATUS = 3'd2;

    localparam logic [1:0] c_OPC_PROG  = 2'b01;
    localparam logic [1:0] c_OPC_ERASE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WREN   = 3'd1,
        S_GAP    = 3'd2,
        S_CMD    = 3'd3,
        S_DATA   = 3'd4,
        S_RDSR_O = 3'd5,
        S_RDSR_I = 3'd6,
        S_CHECK  = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/qspi_wr_shifter.sv
// ============================================================================
// Module : qspi_wr_shifter
// Brief  : SPI mode-0 bit engine: sck at HCLK/2, MSB-first out-shift (single
//          or quad), MISO capture. A load on the done cycle chains segments
//          inside one chip-select frame without a pause in sck.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qspi_wr_shifter (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic [5:0]  i_nsck,
    input  logic        i_quad,
    input  logic        i_oe,
    input  logic        i_miso,
    output logic        o_done,
    output logic        o_sck,
    output logic        o_ce_n,
    output logic [3:0]  o_dout,
    output logic        o_douten,
    output logic [7:0]  o_rx
);

    logic        r_active;
    logic        r_sck;
    logic        r_quad;
    logic        r_oe;
    logic [5:0]  r_cnt;
    logic [31:0] r_sr;
    logic [7:0]  r_rx;
    logic        w_done;
    logic        w_load;

    // done marks the edge on which sck falls after the last rising edge
    assign w_done = r_active & r_sck & (r_cnt == 6'd1);
    assign w_load = i_load & (~r_active | w_done);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_active <= 1'b0;
            r_sck    <= 1'b0;
            r_quad   <= 1'b0;
            r_oe     <= 1'b0;
            r_cnt    <= 6'd0;
            r_sr     <= 32'h0;
            r_rx     <= 8'h0;
        end else begin
            if (r_active && r_sck) begin
                r_rx <= {r_rx[6:0], i_miso};
            end
            if (w_load) begin
                r_active <= 1'b1;
                r_sck    <= 1'b0;
                r_sr     <= i_data;
                r_cnt    <= i_nsck;
                r_quad   <= i_quad;
                r_oe     <= i_oe;
            end else if (r_active) begin
                r_sck <= ~r_sck;
                if (r_sck) begin
                    r_sr  <= r_quad ? {r_sr[27:0], 4'h0} : {r_sr[30:0], 1'b0};
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_active <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_done   = w_done;
    assign o_sck    = r_sck;
    assign o_ce_n   = ~r_active;
    assign o_douten = r_active & r_oe;
    assign o_rx     = r_rx;
    assign o_dout   = !r_active ? 4'b1100 :
                      r_quad    ? r_sr[31:28] : {3'b110, r_sr[31]};

endmodule

`default_nettype wire

// File: rtl/qspi_flash_writer.sv
// ============================================================================
// Module : qspi_flash_writer
// Brief  : AHB-Lite programmer for external SPI flash: WREN, page program or
//          4 KB sector erase, then RDSR polling until WIP clears.
//          Define QSPI_WR_QUAD_EN for Quad Page Program (0x32) data phase.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qspi_flash_writer
    import qspi_wr_pkg::*;
#(
    parameter int POLL_GAP   = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        sck,
    output logic        ce_n,
    input  logic [3:0]  din,
    output logic [3:0]  dout,
    output logic        douten,
    output logic        busy
);

`ifdef QSPI_WR_QUAD_EN
    localparam logic [7:0] c_PROG_OP  = c_OP_QPP;
    localparam logic       c_QUAD     = 1'b1;
    localparam logic [5:0] c_BYTE_SCK = 6'd2;
`else
    localparam logic [7:0] c_PROG_OP  = c_OP_PP;
    localparam logic       c_QUAD     = 1'b0;
    localparam logic [5:0] c_BYTE_SCK = 6'd8;
`endif

    localparam int         c_WORDS    = LINE_BYTES / 4;
    localparam logic [7:0] c_GAP_LAST = 8'(POLL_GAP - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_ap_valid;
    logic        r_ap_write;
    logic [2:0]  r_ap_addr;
    logic [23:0] r_addr;
    logic [31:0] r_data [c_WORDS];
    logic [1:0]  r_op;
    logic [3:0]  r_len;
    logic [3:0]  r_idx;
    logic [7:0]  r_gap_cnt;
    logic        r_gap_to_cmd;
    logic        r_done;
    logic        r_err;

    logic        w_busy;
    logic        w_wr;
    logic        w_wr_locked;
    logic        w_start;
    logic        w_clr;
    logic        w_load;
    logic [31:0] w_ld_data;
    logic [5:0]  w_ld_nsck;
    logic        w_ld_quad;
    logic        w_ld_oe;
    logic        w_set_done;
    logic        w_sh_done;
    logic [7:0]  w_rx;
    logic [3:0]  w_byte_idx;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [7:0]  w_opcode;
    logic        w_unused;

    assign w_busy      = (r_state != S_IDLE);
    assign w_wr        = r_ap_valid & r_ap_write;
    assign w_wr_locked = w_wr & ((r_ap_addr == c_REG_ADDR) | (r_ap_addr == c_REG_CTRL) | r_ap_addr[2]);
    assign w_start     = w_wr & ~w_busy & (r_ap_addr == c_REG_CTRL) &
                         ((HWDATA[1:0] == c_OPC_PROG) | (HWDATA[1:0] == c_OPC_ERASE));
    assign w_clr       = w_wr & (r_ap_addr == c_REG_STATUS);
    assign w_opcode    = (r_op == c_OPC_ERASE) ? c_OP_SE : c_PROG_OP;
    assign w_byte_idx  = (r_state == S_DATA) ? (r_idx + 4'd1) : 4'd0;
    assign w_word      = r_data[w_byte_idx[3:2]];
    assign w_byte      = w_word[{w_byte_idx[1:0], 3'b000} +: 8];
    assign w_unused    = &{1'b0, HADDR[31:5], HADDR[1:0], HTRANS[0], din[3:2], din[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ap_valid <= 1'b0;
            r_ap_write <= 1'b0;
            r_ap_addr  <= 3'd0;
        end else if (HREADY) begin
            r_ap_valid <= HSEL & HTRANS[1];
            if (HSEL && HTRANS[1]) begin
                r_ap_write <= HWRITE;
                r_ap_addr  <= HADDR[4:2];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr <= 24'h0;
            r_op   <= 2'b00;
            r_len  <= 4'h0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            for (int i = 0; i < c_WORDS; i++) begin
                r_data[i] <= 32'h0;
            end
        end else begin
            if (w_wr && !w_busy && r_ap_addr == c_REG_ADDR) begin
                r_addr <= HWDATA[23:0];
            end
            if (w_wr && !w_busy && r_ap_addr[2]) begin
                r_data[r_ap_addr[1:0]] <= HWDATA;
            end
            if (w_start) begin
                r_op  <= HWDATA[1:0];
                r_len <= HWDATA[11:8];
            end
            // a set event on the same cycle as write-1-to-clear wins
            r_done <= w_set_done | (r_done & ~(w_clr & HWDATA[1]));
            r_err  <= (w_wr_locked & w_busy) | (r_err & ~(w_clr & HWDATA[2]));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_idx        <= 4'd0;
            r_gap_cnt    <= 8'd0;
            r_gap_to_cmd <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load && w_next == S_DATA) begin
                r_idx <= w_byte_idx;
            end
            // polls enter GAP one cycle late via CHECK, so start the count at 1
            if (w_next == S_GAP && r_state != S_GAP) begin
                r_gap_cnt    <= (r_state == S_CHECK) ? 8'd1 : 8'd0;
                r_gap_to_cmd <= (r_state == S_WREN);
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_ld_data  = 32'h0;
        w_ld_nsck  = 6'd8;
        w_ld_quad  = 1'b0;
        w_ld_oe    = 1'b1;
        w_set_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next    = S_WREN;
                    w_load    = 1'b1;
                    w_ld_data = {c_OP_WREN, 24'h0};
                end
            end
            S_WREN: begin
                if (w_sh_done) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_load = 1'b1;
                    if (r_gap_to_cmd) begin
                        w_next    = S_CMD;
                        w_ld_data = {w_opcode, r_addr};
                        w_ld_nsck = 6'd32;
                    end else begin
                        w_next    = S_RDSR_O;
                        w_ld_data = {c_OP_RDSR, 24'h0};
                    end
                end
            end
            S_CMD, S_DATA: begin
                if (w_sh_done) begin
                    if ((r_state == S_CMD && r_op == c_OPC_PROG) ||
                        (r_state == S_DATA && r_idx != r_len)) begin
                        w_next    = S_DATA;
                        w_load    = 1'b1;
                        w_ld_data = {w_byte, 24'h0};
                        w_ld_nsck = c_BYTE_SCK;
                        w_ld_quad = c_QUAD;
                    end else begin
                        w_next = S_GAP;
                    end
                end
            end
            S_RDSR_O: begin
                if (w_sh_done) begin
                    w_next  = S_RDSR_I;
                    w_load  = 1'b1;
                    w_ld_oe = 1'b0;
                end
            end
            S_RDSR_I: begin
                if (w_sh_done) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_rx[0]) begin
                    w_next = S_GAP;
                end else begin
                    w_next     = S_IDLE;
                    w_set_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    qspi_wr_shifter u_shifter (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .i_load   (w_load),
        .i_data   (w_ld_data),
        .i_nsck   (w_ld_nsck),
        .i_quad   (w_ld_quad),
        .i_oe     (w_ld_oe),
        .i_miso   (din[1]),
        .o_done   (w_sh_done),
        .o_sck    (sck),
        .o_ce_n   (ce_n),
        .o_dout   (dout),
        .o_douten (douten),
        .o_rx     (w_rx)
    );

    always_comb begin
        HRDATA = 32'h0;
        if (r_ap_addr[2]) begin
            HRDATA = r_data[r_ap_addr[1:0]];
        end else if (r_ap_addr == c_REG_ADDR) begin
            HRDATA = {8'h0, r_addr};
        end else if (r_ap_addr == c_REG_STATUS) begin
            HRDATA = {29'h0, r_err, r_done, w_busy};
        end
    end

    assign HREADYOUT = 1'b1;
    assign busy      = w_busy;

endmodule

`default_nettype wire
